asteroids_stage_ctrl: RTL and testbench

Sequencer for the asteroids special stage. It sits directly upstream and downstream of the asteroid field block. It drives that block's enable and its active-low reset, and consumes its explode pulse and all-destroyed flag. It also counts player hits, issues score increments, and reports the stage result to the top-level game FSM.

---
 rtl/asteroids_stage_ctrl.sv | 164 ++++++++++++++++
 tb/tb_asteroids_stage_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroids_stage_ctrl.sv
// Asteroids special-stage sequencer: intro freeze, active play, outro freeze, result report.
// Optional time bonus on a win is enabled by defining ASTEROIDS_TIME_BONUS_EN.
module asteroids_stage_ctrl #(
    parameter int INTRO_FRAMES         = 60,
    parameter int STAGE_TIMEOUT_FRAMES = 1800,
    parameter int OUTRO_FRAMES         = 60,
    parameter int MAX_HITS             = 3,
    parameter int POINTS_PER_ASTEROID  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       start_stage,
    input  logic       asteroid_exploded_pulse,
    input  logic       all_asteroids_destroied,
    input  logic       player_hit,
    output logic       asteroids_enable,
    output logic       asteroids_resetN,
    output logic       score_add_pulse,
    output logic [7:0] score_add_value,
    output logic [3:0] destroyed_count,
    output logic       stage_done,
    output logic       stage_won,
    output logic       busy
);

    localparam logic [10:0] INTRO_LAST   = 11'(INTRO_FRAMES - 1);
    localparam logic [10:0] TIMEOUT_LAST = 11'(STAGE_TIMEOUT_FRAMES - 1);
    localparam logic [10:0] OUTRO_LAST   = 11'(OUTRO_FRAMES - 1);
    localparam logic [7:0]  HIT_LIMIT    = 8'(MAX_HITS);
    localparam logic [7:0]  POINTS       = 8'(POINTS_PER_ASTEROID);

    typedef enum logic [2:0] {
        IDLE,
        INTRO,
        ACTIVE,
        OUTRO,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] frame_cnt;
    logic [7:0]  hit_cnt;
    logic [7:0]  hits_total;
    logic        win;
    logic        explode_strobe;

    always_comb begin
        state_nxt      = state;
        win            = 1'b0;
        hits_total     = hit_cnt + {7'd0, player_hit};
        explode_strobe = (state == ACTIVE) && asteroid_exploded_pulse;
        case (state)
            IDLE: begin
                if (start_stage) state_nxt = INTRO;
            end
            INTRO: begin
                if (startOfFrame && frame_cnt == INTRO_LAST) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                // Win outranks a simultaneous final hit or timeout.
                if (all_asteroids_destroied) begin
                    win       = 1'b1;
                    state_nxt = OUTRO;
                end else if (hits_total >= HIT_LIMIT) begin
                    state_nxt = OUTRO;
                end else if (startOfFrame && frame_cnt == TIMEOUT_LAST) begin
                    state_nxt = OUTRO;
                end
            end
            OUTRO: begin
                if (startOfFrame && frame_cnt == OUTRO_LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ASTEROIDS_TIME_BONUS_EN
    logic [31:0] bonus_raw;
    logic [7:0]  bonus_value;
    logic [7:0]  bonus_hold;
    logic        bonus_pending;

    always_comb begin
        bonus_raw   = (32'(STAGE_TIMEOUT_FRAMES - 1) - 32'(frame_cnt)) >> 6;
        bonus_value = (bonus_raw > 32'd255) ? 8'hFF : bonus_raw[7:0];
    end

    // An explode strobe due on the win clock goes first; the bonus waits one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_add_pulse <= 1'b0;
            score_add_value <= '0;
            bonus_pending   <= 1'b0;
            bonus_hold      <= '0;
        end else if (explode_strobe) begin
            score_add_pulse <= 1'b1;
            score_add_value <= POINTS;
            bonus_pending   <= win;
            bonus_hold      <= bonus_value;
        end else if (win) begin
            score_add_pulse <= 1'b1;
            score_add_value <= bonus_value;
        end else if (bonus_pending) begin
            score_add_pulse <= 1'b1;
            score_add_value <= bonus_hold;
            bonus_pending   <= 1'b0;
        end else begin
            score_add_pulse <= 1'b0;
            score_add_value <= '0;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_add_pulse <= 1'b0;
            score_add_value <= '0;
        end else begin
            score_add_pulse <= explode_strobe;
            score_add_value <= explode_strobe ? POINTS : '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            frame_cnt        <= '0;
            hit_cnt          <= '0;
            destroyed_count  <= '0;
            stage_won        <= 1'b0;
            asteroids_enable <= 1'b0;
            asteroids_resetN <= 1'b0;
            stage_done       <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) frame_cnt <= '0;
            else if (startOfFrame)  frame_cnt <= frame_cnt + 11'd1;

            if (state == IDLE && start_stage) begin
                hit_cnt         <= '0;
                destroyed_count <= '0;
                stage_won       <= 1'b0;
            end

            if (state == ACTIVE) begin
                if (asteroid_exploded_pulse && destroyed_count != 4'hF)
                    destroyed_count <= destroyed_count + 4'd1;
                if (player_hit) hit_cnt <= hits_total;
                if (state_nxt == OUTRO) stage_won <= win;
            end

            // Outputs decode the upcoming state so they are registered yet aligned with it.
            asteroids_enable <= (state_nxt == ACTIVE);
            asteroids_resetN <= (state_nxt != IDLE);
            busy             <= (state_nxt != IDLE);
            stage_done       <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_asteroids_stage_ctrl.sv
// Self-checking bench for asteroids_stage_ctrl: per-cycle reference model plus directed literal checks.
module tb_asteroids_stage_ctrl;

    localparam int INTRO   = 60;
    localparam int TIMEOUT = 1800;
    localparam int OUTRO   = 60;
    localparam int MAXH    = 3;
    localparam int PTS     = 5;

    localparam int P_IDLE   = 0;
    localparam int P_INTRO  = 1;
    localparam int P_ACTIVE = 2;
    localparam int P_OUTRO  = 3;
    localparam int P_DONE   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sof = 1'b0, start = 1'b0, expl = 1'b0, all_d = 1'b0, hit = 1'b0;
    logic       asteroids_enable, asteroids_resetN, score_add_pulse, stage_done, stage_won, busy;
    logic [7:0] score_add_value;
    logic [3:0] destroyed_count;

    asteroids_stage_ctrl #(
        .INTRO_FRAMES(INTRO),
        .STAGE_TIMEOUT_FRAMES(TIMEOUT),
        .OUTRO_FRAMES(OUTRO),
        .MAX_HITS(MAXH),
        .POINTS_PER_ASTEROID(PTS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(sof),
        .start_stage(start),
        .asteroid_exploded_pulse(expl),
        .all_asteroids_destroied(all_d),
        .player_hit(hit),
        .asteroids_enable(asteroids_enable),
        .asteroids_resetN(asteroids_resetN),
        .score_add_pulse(score_add_pulse),
        .score_add_value(score_add_value),
        .destroyed_count(destroyed_count),
        .stage_done(stage_done),
        .stage_won(stage_won),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus frames seen in it; strobes are a FIFO drained one per clock.
    int  m_phase = P_IDLE, m_frames = 0, m_hits = 0, m_destroyed = 0;
    bit  m_won = 0;
    int  m_q[$];
    bit  e_en = 0, e_rn = 0, e_pulse = 0, e_done = 0, e_won = 0, e_busy = 0;
    int  e_val = 0;

    always @(posedge clk or posedge reset) begin
        bit leave;
        if (reset) begin
            m_phase = P_IDLE; m_frames = 0; m_hits = 0; m_destroyed = 0; m_won = 0;
            m_q.delete();
            e_pulse = 0; e_val = 0;
        end else begin
            leave = 0;
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase = P_INTRO; m_frames = 0; m_hits = 0; m_destroyed = 0; m_won = 0;
                end
                P_INTRO: if (sof) begin
                    if (m_frames == INTRO - 1) begin m_phase = P_ACTIVE; m_frames = 0; end
                    else m_frames++;
                end
                P_ACTIVE: begin
                    if (expl) begin
                        if (m_destroyed < 15) m_destroyed++;
                        m_q.push_back(PTS);
                    end
                    if (hit) m_hits++;
                    if (all_d) begin
                        leave = 1; m_won = 1;
`ifdef ASTEROIDS_TIME_BONUS_EN
                        m_q.push_back(((TIMEOUT - 1 - m_frames) / 64) > 255 ? 255 : (TIMEOUT - 1 - m_frames) / 64);
`endif
                    end else if (m_hits >= MAXH) leave = 1;
                    else if (sof && m_frames == TIMEOUT - 1) leave = 1;
                    if (leave) begin m_phase = P_OUTRO; m_frames = 0; end
                    else if (sof) m_frames++;
                end
                P_OUTRO: if (sof) begin
                    if (m_frames == OUTRO - 1) begin m_phase = P_DONE; m_frames = 0; end
                    else m_frames++;
                end
                default: begin m_phase = P_IDLE; m_frames = 0; end
            endcase
            if (m_q.size() > 0) begin e_pulse = 1; e_val = m_q.pop_front(); end
            else begin e_pulse = 0; e_val = 0; end
        end
        e_en   = (m_phase == P_ACTIVE);
        e_rn   = (m_phase != P_IDLE);
        e_busy = (m_phase != P_IDLE);
        e_done = (m_phase == P_DONE);
        e_won  = m_won;
    end

    always @(negedge clk) begin
        if (checks > 0 || reset) begin
            chk("enable", asteroids_enable, e_en);
            chk("resetN", asteroids_resetN, e_rn);
            chk("busy", busy, e_busy);
            chk("stage_done", stage_done, e_done);
            chk("stage_won", stage_won, e_won);
            chk("score_pulse", score_add_pulse, e_pulse);
            chk("score_value", score_add_value, e_val);
            chk("destroyed", destroyed_count, m_destroyed);
        end
    end

    int strobe_cnt = 0, strobe_sum = 0, done_cnt = 0;
    int seen[$];
    always @(negedge clk) begin
        if (score_add_pulse) begin
            strobe_cnt++;
            strobe_sum += int'(score_add_value);
            seen.push_back(int'(score_add_value));
        end
        if (stage_done) done_cnt++;
    end

    task automatic cyc(input bit s, input bit st, input bit ex, input bit al, input bit h);
        sof = s; start = st; expl = ex; all_d = al; hit = h;
        @(posedge clk); #1;
        sof = 0; start = 0; expl = 0; all_d = 0; hit = 0;
    endtask

    task automatic until_enable(input int budget, output int sofs);
        bit s;
        sofs = 0;
        for (int i = 0; i < budget && !asteroids_enable; i++) begin
            s = 1'($urandom_range(0, 1));
            if (s) sofs++;
            cyc(s, 0, 0, 0, 0);
        end
        if (!asteroids_enable) chk("enable_wait_expired", 0, 1);
    endtask

    task automatic enter_active();
        int n;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        until_enable(1000, n);
    endtask

    task automatic until_done(input int budget);
        for (int i = 0; i < budget && !stage_done; i++) cyc(1'($urandom_range(0, 1)), 0, 0, 0, 0);
        if (!stage_done) chk("done_wait_expired", 0, 1);
    endtask

    initial begin
        int n, base_cnt, base_sum, base_done, base_seen;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resetN", asteroids_resetN, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;

        // Intro length and field release.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("resetN_after_start", asteroids_resetN, 1);
        chk("busy_after_start", busy, 1);
        chk("enable_in_intro", asteroids_enable, 0);
        until_enable(1000, n);
        chk("intro_frame_count", n, 60);

        // Four explosions then a clear field: win.
        base_cnt = strobe_cnt; base_sum = strobe_sum;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("win_destroyed", destroyed_count, 4);
        chk("win_enable_off", asteroids_enable, 0);
`ifdef ASTEROIDS_TIME_BONUS_EN
        chk("win_strobe_count", strobe_cnt - base_cnt, 5);
`else
        chk("win_strobe_count", strobe_cnt - base_cnt, 4);
        chk("win_strobe_sum", strobe_sum - base_sum, 20);
`endif
        until_done(2000);
        chk("win_stage_won", stage_won, 1);
        cyc(0, 0, 0, 0, 0);
        chk("done_one_clock", stage_done, 0);
        chk("idle_after_done", busy, 0);
        chk("won_holds", stage_won, 1);

        // Three hits: loss on the third, later explosions ignored.
        enter_active();
        chk("won_cleared", stage_won, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        chk("two_hits_still_active", asteroids_enable, 1);
        cyc(0, 0, 0, 0, 1);
        chk("third_hit_exit", asteroids_enable, 0);
        chk("hit_loss_won", stage_won, 0);
        base_cnt = strobe_cnt;
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("outro_no_strobes", strobe_cnt - base_cnt, 0);
        chk("outro_no_count", destroyed_count, 0);
        until_done(2000);
        chk("hit_done_won", stage_won, 0);

        // Timeout with no events.
        enter_active();
        n = 0;
        for (int i = 0; i < 3000 && asteroids_enable; i++) begin
            n++;
            cyc(1, 0, 0, 0, 0);
        end
        chk("timeout_frames", n, 1800);
        until_done(2000);
        chk("timeout_won", stage_won, 0);

        // Win, last hit and explosion on one clock.
        enter_active();
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
`ifdef ASTEROIDS_TIME_BONUS_EN
        for (int i = 0; i < 640; i++) cyc(1, 0, 0, 0, 0);
`endif
        base_seen = seen.size();
        cyc(0, 0, 1, 1, 1);
        chk("combo_won", stage_won, 1);
        chk("combo_destroyed", destroyed_count, 1);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
`ifdef ASTEROIDS_TIME_BONUS_EN
        chk("combo_strobes", seen.size() - base_seen, 2);
        if (seen.size() - base_seen == 2) begin
            chk("combo_first_strobe", seen[base_seen], 5);
            chk("combo_bonus_strobe", seen[base_seen + 1], 18);
        end
`else
        chk("combo_strobes", seen.size() - base_seen, 1);
        if (seen.size() > base_seen) chk("combo_strobe_value", seen[base_seen], 5);
`endif
        until_done(2000);

        // Reset mid-ACTIVE at frame 100.
        enter_active();
        for (int i = 0; i < 100; i++) cyc(1, 0, 0, 0, 0);
        chk("pre_reset_enable", asteroids_enable, 1);
        base_done = done_cnt;
        reset = 1'b1;
        #1;
        chk("async_reset_resetN", asteroids_resetN, 0);
        chk("async_reset_enable", asteroids_enable, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_destroyed", destroyed_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("no_done_after_reset", done_cnt - base_done, 0);
        cyc(0, 1, 0, 0, 0);
        chk("restart_resetN", asteroids_resetN, 1);
        chk("restart_busy", busy, 1);

        // Randomised traffic: first hit-heavy, then explosion-heavy to reach saturation.
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < 10000; i++) begin
                if ($urandom_range(0, 4999) == 0) begin
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                end
                cyc(1'($urandom_range(0, 1)),
                    $urandom_range(0, 19) == 0,
                    seg == 0 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 1) == 0,
                    $urandom_range(0, 399) == 0,
                    seg == 0 ? $urandom_range(0, 39) == 0 : $urandom_range(0, 299) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
